// File: rtl/common.sv
// Shared definitions for the keyboard front end: machine/turbo types,
// receiver state encoding, PS/2 scan-code constants and a parity helper.
package common;

  typedef enum logic [1:0] {
    MACH_48K,
    MACH_128K,
    MACH_PENTAGON,
    MACH_SCORPION
  } machine_t;

  typedef enum logic [1:0] {
    TURBO_NONE,
    TURBO_X2,
    TURBO_X4,
    TURBO_X8
  } turbo_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 4095;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_F11    = 8'h78;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_DEL    = 8'h71;
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: synchronises and deglitches the keyboard lines, frames
// start/data/parity/stop bits and aborts frames that stall mid-way.
module ps2_rx
  import common::*;
(
  input  logic       clk28,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       timeout
);

  localparam int FLT_W = $clog2(FILTER_LEN);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  logic             r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic             r_clk_f;
  logic [FLT_W-1:0] r_flt_cnt;
  rx_state_t        r_state, w_state_nxt;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic             r_par;
  logic [TO_W-1:0]  r_idle_cnt;
  logic [7:0]       r_code;
  logic             r_code_valid;
  logic             r_timeout;
  logic             w_flt_flip, w_fall, w_timeout;

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_dat;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Filtered clock flips on the FILTER_LEN-th consecutive differing sample.
  assign w_flt_flip = (r_clk_s2 != r_clk_f) && (r_flt_cnt == FLT_W'(FILTER_LEN - 1));
  assign w_fall     = w_flt_flip & r_clk_f;
  assign w_timeout  = (r_state != IDLE) && (r_idle_cnt == TO_W'(TIMEOUT));

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_flt_cnt <= '0;
      r_clk_f   <= 1'b1;
    end else if (r_clk_s2 == r_clk_f) begin
      r_flt_cnt <= '0;
    end else if (w_flt_flip) begin
      r_flt_cnt <= '0;
      r_clk_f   <= r_clk_s2;
    end else begin
      r_flt_cnt <= r_flt_cnt + FLT_W'(1);
    end
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = IDLE;
    end else if (w_fall) begin
      case (r_state)
        IDLE:    w_state_nxt = r_dat_s2 ? IDLE : DATA;
        DATA:    w_state_nxt = (r_bit_cnt == 3'd7) ? PARITY : DATA;
        PARITY:  w_state_nxt = STOP;
        STOP:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_shift      <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_par        <= 1'b0;
      r_code       <= 8'h00;
      r_code_valid <= 1'b0;
    end else begin
      r_code_valid <= 1'b0;
      if (w_fall && !w_timeout) begin
        case (r_state)
          IDLE: r_bit_cnt <= 3'd0;
          DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          PARITY: r_par <= r_dat_s2;
          STOP: begin
            if (r_dat_s2 && odd_parity_ok(r_shift, r_par)) begin
              r_code       <= r_shift;
              r_code_valid <= 1'b1;
            end
          end
          default: r_bit_cnt <= 3'd0;
        endcase
      end
    end
  end

  // Idle watchdog: any filtered edge proves the keyboard is still clocking.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
      if (w_flt_flip || (r_state == IDLE) || w_timeout) r_idle_cnt <= '0;
      else                                              r_idle_cnt <= r_idle_cnt + TO_W'(1);
    end
  end

  assign code       = r_code;
  assign code_valid = r_code_valid;
  assign timeout    = r_timeout;

endmodule

// File: rtl/ps2_hotkeys.sv
// Hotkey decoder on top of the PS/2 receiver: tracks E0/F0/E1 prefixes and
// drives the magic (F11), pause (Pause/Break) and reboot (Ctrl+Alt+Del) levels.
module ps2_hotkeys
  import common::*;
(
  input  logic       clk28,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       magic_button,
  output logic       pause_button,
  output logic       reboot_button,
  output logic       code_valid,
  output logic [7:0] code
);

  logic [7:0] w_code;
  logic       w_code_valid, w_timeout, w_held;
  logic       r_ext, r_brk;
  logic [2:0] r_e1_skip;
  logic       r_magic, r_pause, r_reboot;
  logic       r_ctrl_l, r_ctrl_r, r_alt_l, r_alt_r, r_del;

  ps2_rx u_rx (
    .clk28      (clk28),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .code       (w_code),
    .code_valid (w_code_valid),
    .timeout    (w_timeout)
  );

  assign w_held = ~r_brk;

  // Prefix bytes accumulate in any order; the Pause sequence swallows 7 trailing bytes.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_ext     <= 1'b0;
      r_brk     <= 1'b0;
      r_e1_skip <= 3'd0;
      r_magic   <= 1'b0;
      r_pause   <= 1'b0;
      r_ctrl_l  <= 1'b0;
      r_ctrl_r  <= 1'b0;
      r_alt_l   <= 1'b0;
      r_alt_r   <= 1'b0;
      r_del     <= 1'b0;
    end else if (w_timeout) begin
      r_ext     <= 1'b0;
      r_brk     <= 1'b0;
      r_e1_skip <= 3'd0;
    end else if (w_code_valid) begin
      if (r_e1_skip != 3'd0) begin
        r_e1_skip <= r_e1_skip - 3'd1;
      end else begin
        case (w_code)
          SC_E1: begin
            r_pause   <= ~r_pause;
            r_e1_skip <= 3'd7;
            r_ext     <= 1'b0;
            r_brk     <= 1'b0;
          end
          SC_E0: r_ext <= 1'b1;
          SC_F0: r_brk <= 1'b1;
          default: begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
            case (w_code)
              SC_F11:  if (!r_ext) r_magic <= w_held;
              SC_CTRL: if (r_ext) r_ctrl_r <= w_held; else r_ctrl_l <= w_held;
              SC_ALT:  if (r_ext) r_alt_r <= w_held; else r_alt_l <= w_held;
              SC_DEL:  if (r_ext) r_del <= w_held;
              SC_BAT_OK, SC_ACK: begin
                r_magic  <= 1'b0;
                r_ctrl_l <= 1'b0;
                r_ctrl_r <= 1'b0;
                r_alt_l  <= 1'b0;
                r_alt_r  <= 1'b0;
                r_del    <= 1'b0;
              end
              default: r_ext <= 1'b0;
            endcase
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) r_reboot <= 1'b0;
    else     r_reboot <= (r_ctrl_l | r_ctrl_r) & (r_alt_l | r_alt_r) & r_del;
  end

  assign magic_button  = r_magic;
  assign pause_button  = r_pause;
  assign reboot_button = r_reboot;
  assign code_valid    = w_code_valid;
  assign code          = w_code;

endmodule
